// File: rtl/regfile_pkg.sv
// Shared types and constants for the banked integer/float register file.
package regfile_pkg;

    typedef enum logic {
        BANK_INT = 1'b0,
        BANK_FLT = 1'b1
    } bank_t;

    localparam logic [31:0] FP_ONE     = 32'h3f800000;
    localparam int          REG_DATA_W = 32;
    localparam int          REG_ADDR_W = 5;

    typedef struct packed {
        bank_t                  fbank;
        logic [REG_ADDR_W-1:0]  addr;
    } rd_req_t;

    typedef struct packed {
        logic                   valid;
        logic                   token;
        bank_t                  fbank;
        logic [REG_ADDR_W-1:0]  addr;
        logic [REG_DATA_W-1:0]  data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_gate.sv
// Toggle-token acceptance for one write port: a request is taken only when its token
// differs from the last accepted one, so a stalled writeback commits exactly once.
module regfile_wr_gate (
    input  logic clk,
    input  logic srst,
    input  logic wr_valid,
    input  logic wr_token,
    output logic acc
);

    logic tok_reg;

    assign acc = wr_valid && (wr_token != tok_reg);

    always_ff @(posedge clk) begin
        if (srst) begin
            tok_reg <= 1'b0;
        end else if (acc) begin
            tok_reg <= wr_token;
        end
    end

endmodule

// File: rtl/banked_regfile.sv
// Two-bank (int/float) register file with registered read ports, token-gated write ports,
// optional write->read forwarding and a per-register busy scoreboard.
module banked_regfile
    import regfile_pkg::*;
#(
    parameter int                     DATA_W  = REG_DATA_W,
    parameter int                     ADDR_W  = REG_ADDR_W,
    parameter int                     NUM_RD  = 3,
    parameter int                     NUM_WR  = 2,
    parameter logic [DATA_W-1:0]      F0_INIT = DATA_W'(FP_ONE),
    parameter bit                     BYPASS  = 1'b1
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [NUM_RD-1:0]         rd_en,
    input  logic [NUM_RD-1:0]         rd_fbank,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD*DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]         rd_busy,
    input  logic [NUM_WR-1:0]         wr_valid,
    input  logic [NUM_WR-1:0]         wr_token,
    input  logic [NUM_WR-1:0]         wr_fbank,
    input  logic [NUM_WR*ADDR_W-1:0]  wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]  wr_data,
    input  logic                      iss_valid,
    input  logic                      iss_fbank,
    input  logic [ADDR_W-1:0]         iss_addr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int IDX_W = ADDR_W + 1;

    // Both banks share one flat array indexed by {bank, index}.
    logic [DATA_W-1:0] mem_reg  [2*DEPTH];
    logic              busy_reg [2*DEPTH];

    logic [NUM_WR-1:0] acc;
    logic [IDX_W-1:0]  wr_idx  [NUM_WR];
    logic [DATA_W-1:0] wr_word [NUM_WR];
    logic [IDX_W-1:0]  iss_idx;

    assign iss_idx = {bank_t'(iss_fbank), iss_addr};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
            regfile_wr_gate u_gate (
                .clk      (CLK),
                .srst     (reset),
                .wr_valid (wr_valid[gi]),
                .wr_token (wr_token[gi]),
                .acc      (acc[gi])
            );
            assign wr_idx[gi]  = {bank_t'(wr_fbank[gi]), wr_addr[gi*ADDR_W +: ADDR_W]};
            assign wr_word[gi] = wr_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Later ports overwrite earlier ones, giving the highest port priority on a collision.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 2*DEPTH; i++) begin
                mem_reg[i]  <= (i == DEPTH) ? F0_INIT : '0;
                busy_reg[i] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (acc[k]) begin
                    mem_reg[wr_idx[k]]  <= wr_word[k];
                    busy_reg[wr_idx[k]] <= 1'b0;
                end
            end
            if (iss_valid) begin
                busy_reg[iss_idx] <= 1'b1;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [IDX_W-1:0]  rd_idx;
            logic [DATA_W-1:0] rd_val;
            logic              rd_bsy;
            logic [DATA_W-1:0] rd_data_reg;
            logic              rd_busy_reg;

            assign rd_idx = {bank_t'(rd_fbank[gi]), rd_addr[gi*ADDR_W +: ADDR_W]};

            // Forwarded view mirrors the update order of the storage block above.
            always_comb begin
                rd_val = mem_reg[rd_idx];
                rd_bsy = busy_reg[rd_idx];
                if (BYPASS) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (acc[k] && (wr_idx[k] == rd_idx)) begin
                            rd_val = wr_word[k];
                            rd_bsy = 1'b0;
                        end
                    end
                    if (iss_valid && (iss_idx == rd_idx)) begin
                        rd_bsy = 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (reset) begin
                    rd_data_reg <= '0;
                    rd_busy_reg <= 1'b0;
                end else if (rd_en[gi]) begin
                    rd_data_reg <= rd_val;
                    rd_busy_reg <= rd_bsy;
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = rd_data_reg;
            assign rd_busy[gi]                  = rd_busy_reg;
        end
    endgenerate

endmodule

// File: tb/tb_banked_regfile.sv
// Directed self-checking bench for banked_regfile with default parameters (BYPASS=1).
module tb_banked_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 3;
    localparam int NUM_WR = 2;

    logic                     CLK = 1'b0;
    logic                     reset;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD-1:0]        rd_fbank;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_valid;
    logic [NUM_WR-1:0]        wr_token;
    logic [NUM_WR-1:0]        wr_fbank;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     iss_valid;
    logic                     iss_fbank;
    logic [ADDR_W-1:0]        iss_addr;

    int checks   = 0;
    int failures = 0;

    banked_regfile dut (
        .CLK       (CLK),
        .reset     (reset),
        .rd_en     (rd_en),
        .rd_fbank  (rd_fbank),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_valid  (wr_valid),
        .wr_token  (wr_token),
        .wr_fbank  (wr_fbank),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_fbank (iss_fbank),
        .iss_addr  (iss_addr)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int p, input logic en, input logic fb, input logic [ADDR_W-1:0] a);
        rd_en[p]                   = en;
        rd_fbank[p]                = fb;
        rd_addr[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_wr(input int k, input logic v, input logic tok, input logic fb,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_valid[k]                 = v;
        wr_token[k]                 = tok;
        wr_fbank[k]                 = fb;
        wr_addr[k*ADDR_W +: ADDR_W] = a;
        wr_data[k*DATA_W +: DATA_W] = d;
    endtask

    function automatic logic [31:0] rdat(input int p);
        return rd_data[p*DATA_W +: DATA_W];
    endfunction

    initial begin
        reset     = 1'b1;
        rd_en     = '0;
        rd_fbank  = '0;
        rd_addr   = '0;
        wr_valid  = '0;
        wr_token  = '0;
        wr_fbank  = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_fbank = 1'b0;
        iss_addr  = '0;
        tick();
        tick();
        check("reset_rd_data0", rdat(0), 32'h0);
        check("reset_rd_busy", {29'd0, rd_busy}, 32'h0);

        // 1: reset contents
        reset = 1'b0;
        set_rd(0, 1'b1, 1'b1, 5'd0);
        set_rd(1, 1'b1, 1'b0, 5'd0);
        tick();
        check("t1_flt0", rdat(0), 32'h3f800000);
        check("t1_int0", rdat(1), 32'h0);
        check("t1_busy", {29'd0, rd_busy}, 32'h0);
        rd_en = '0;

        // 2: held request writes once
        set_wr(0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
        repeat (4) tick();
        set_wr(0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h00000001);
        tick();
        set_wr(0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h00000001);
        set_rd(0, 1'b1, 1'b0, 5'd5);
        tick();
        check("t2_int5_once", rdat(0), 32'hDEADBEEF);

        // 3: colliding writes, highest port wins (forwarded and stored)
        set_wr(0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h11111111);
        set_wr(1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h22222222);
        set_rd(1, 1'b1, 1'b1, 5'd7);
        rd_en[0] = 1'b0;
        tick();
        check("t3_fwd_flt7", rdat(1), 32'h22222222);
        wr_valid = '0;
        set_rd(0, 1'b1, 1'b1, 5'd7);
        rd_en[1] = 1'b0;
        tick();
        check("t3_flt7", rdat(0), 32'h22222222);
        check("t3_hold_port1", rdat(1), 32'h22222222);

        // 4: same-cycle bypass
        set_wr(0, 1'b1, 1'b1, 1'b0, 5'd3, 32'hA5A5A5A5);
        set_rd(2, 1'b1, 1'b0, 5'd3);
        rd_en[0] = 1'b0;
        tick();
        check("t4_bypass_int3", rdat(2), 32'hA5A5A5A5);
        wr_valid = '0;
        rd_en    = '0;

        // 5: scoreboard
        iss_valid = 1'b1; iss_fbank = 1'b0; iss_addr = 5'd9;
        tick();
        iss_valid = 1'b0;
        set_rd(0, 1'b1, 1'b0, 5'd9);
        tick();
        check("t5_busy_set", {31'd0, rd_busy[0]}, 32'h1);
        set_wr(1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h00000009);
        iss_valid = 1'b1;
        tick();
        check("t5_issue_wins", {31'd0, rd_busy[0]}, 32'h1);
        check("t5_data9", rdat(0), 32'h00000009);
        iss_valid = 1'b0;
        set_wr(1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000000A);
        tick();
        check("t5_busy_clr_fwd", {31'd0, rd_busy[0]}, 32'h0);
        wr_valid = '0;
        tick();
        check("t5_busy_clr", {31'd0, rd_busy[0]}, 32'h0);
        check("t5_data10", rdat(0), 32'h0000000A);
        set_rd(0, 1'b0, 1'b0, 5'd5);
        tick();
        check("t5_rd_en_hold", rdat(0), 32'h0000000A);

        // int reg 0 is an ordinary writable register (port1 token currently 1)
        set_wr(1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h00000123);
        tick();
        wr_valid = '0;
        set_rd(1, 1'b1, 1'b0, 5'd0);
        tick();
        check("t5_int0_write", rdat(1), 32'h00000123);
        rd_en = '0;

        // 6: reset discards in-flight write and clears tokens
        set_wr(0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h00000005);
        reset = 1'b1;
        tick();
        check("t6_rst_rd_data", rdat(1), 32'h0);
        reset    = 1'b0;
        wr_valid = '0;
        set_rd(0, 1'b1, 1'b0, 5'd4);
        set_rd(1, 1'b1, 1'b1, 5'd0);
        set_rd(2, 1'b1, 1'b1, 5'd7);
        tick();
        check("t6_int4_dropped", rdat(0), 32'h0);
        check("t6_flt0_init", rdat(1), 32'h3f800000);
        check("t6_flt7_cleared", rdat(2), 32'h0);
        rd_en = '0;
        set_wr(0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h00000007);
        tick();
        set_wr(0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h00000008);
        tick();
        wr_valid = '0;
        set_rd(0, 1'b1, 1'b0, 5'd4);
        tick();
        check("t6_tok1_accepted", rdat(0), 32'h00000007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
